// File: rtl/ts_packet_mux_pkg.sv
// Shared constants and state encoding for the transport-stream packet mux.
package ts_packet_mux_pkg;

  localparam int unsigned NUM_STREAMS = 4;
  localparam int unsigned PKT_LEN     = 188;
  localparam logic [7:0]  SYNC_BYTE   = 8'h47;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StXfer  = 2'd1,
    StFlush = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way round-robin selector: grants the first requester at or after ptr_i, wrapping 3->0.
module rr_arbiter4
  import ts_packet_mux_pkg::*;
(
  input  logic [NUM_STREAMS-1:0] req_i,
  input  logic [1:0]             ptr_i,
  output logic [NUM_STREAMS-1:0] gnt_o,
  output logic [1:0]             idx_o
);

  logic [1:0] cand;
  logic       found;

  always_comb begin
    gnt_o = '0;
    idx_o = ptr_i;
    found = 1'b0;
    cand  = ptr_i;
    for (int k = 0; k < NUM_STREAMS; k++) begin
      cand = ptr_i + 2'(k);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/ts_packet_mux.sv
// Muxes four byte streams into one, forwarding whole sync-aligned TS packets round-robin.
module ts_packet_mux
  import ts_packet_mux_pkg::*;
#(
  parameter int unsigned PKT_LEN   = ts_packet_mux_pkg::PKT_LEN,
  parameter logic [7:0]  SYNC_BYTE = ts_packet_mux_pkg::SYNC_BYTE
) (
  input  logic        clk2,
  input  logic        rst_n,
  input  logic [31:0] in_data,
  input  logic [3:0]  in_valid,
  output logic [3:0]  in_ready,
  input  logic        out_full,
  output logic [7:0]  out_data,
  output logic        out_wr,
  output logic        out_sop,
  output logic        out_eop,
  output logic [3:0]  valid,
  output logic [1:0]  mux_ctrl,
  output logic [3:0]  sync_err
);

  localparam int unsigned   CntW    = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(PKT_LEN - 1);

  state_e          state_q, state_d;
  logic [1:0]      rr_ptr_q, rr_ptr_d;
  logic [1:0]      gnt_idx_q, gnt_idx_d;
  logic [3:0]      valid_q, valid_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      out_data_q;
  logic            out_wr_q, out_sop_q, out_eop_q;

  logic [3:0] eligible, junk, ready, serr, arb_gnt;
  logic [1:0] arb_idx;
  logic       accept;
  logic [7:0] sel_byte;

  always_comb begin
    eligible = '0;
    junk     = '0;
    for (int i = 0; i < NUM_STREAMS; i++) begin
      eligible[i] = in_valid[i] && (in_data[8*i +: 8] == SYNC_BYTE);
      junk[i]     = in_valid[i] && (in_data[8*i +: 8] != SYNC_BYTE);
    end
  end

  assign sel_byte = in_data[{gnt_idx_q, 3'b000} +: 8];

  rr_arbiter4 u_rr_arbiter4 (
    .req_i (eligible),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx)
  );

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_idx_d = gnt_idx_q;
    valid_d   = valid_q;
    cnt_d     = cnt_q;
    ready     = '0;
    serr      = '0;
    accept    = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Non-sync bytes are drained so a misaligned stream can find its next sync.
        ready = junk;
        serr  = junk;
        if (|eligible) begin
          gnt_idx_d = arb_idx;
          valid_d   = arb_gnt;
          cnt_d     = '0;
          state_d   = StXfer;
        end
      end
      StXfer: begin
        ready[gnt_idx_q] = !out_full;
        accept           = in_valid[gnt_idx_q] && !out_full;
        if (accept) begin
          if (cnt_q == LastCnt) begin
            cnt_d   = '0;
            valid_d = '0;
            state_d = StFlush;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StFlush: begin
        rr_ptr_d = gnt_idx_q + 2'd1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      gnt_idx_q  <= '0;
      valid_q    <= '0;
      cnt_q      <= '0;
      out_data_q <= '0;
      out_wr_q   <= 1'b0;
      out_sop_q  <= 1'b0;
      out_eop_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt_idx_q <= gnt_idx_d;
      valid_q   <= valid_d;
      cnt_q     <= cnt_d;
      out_wr_q  <= accept;
      out_sop_q <= accept && (cnt_q == '0);
      out_eop_q <= accept && (cnt_q == LastCnt);
      if (accept) out_data_q <= sel_byte;
    end
  end

  // Combinational handshakes are forced low while reset is held.
  assign in_ready = rst_n ? ready : '0;
  assign sync_err = rst_n ? serr : '0;
  assign valid    = valid_q;
  assign mux_ctrl = gnt_idx_q;
  assign out_data = out_data_q;
  assign out_wr   = out_wr_q;
  assign out_sop  = out_sop_q;
  assign out_eop  = out_eop_q;

endmodule

// File: tb/tb_ts_packet_mux.sv
// Directed self-checking bench for ts_packet_mux with immediate assertions.
module tb_ts_packet_mux;

  localparam int N = 188;

  logic        clk2 = 1'b0;
  logic        rst_n;
  logic [31:0] in_data;
  logic [3:0]  in_valid, in_ready, valid, sync_err;
  logic        out_full;
  logic [7:0]  out_data;
  logic        out_wr, out_sop, out_eop;
  logic [1:0]  mux_ctrl;

  always #5 clk2 = ~clk2;

  ts_packet_mux #(
    .PKT_LEN   (N),
    .SYNC_BYTE (8'h47)
  ) dut (
    .clk2     (clk2),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_full (out_full),
    .out_data (out_data),
    .out_wr   (out_wr),
    .out_sop  (out_sop),
    .out_eop  (out_eop),
    .valid    (valid),
    .mux_ctrl (mux_ctrl),
    .sync_err (sync_err)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       sop;
    logic       eop;
  } wr_t;

  wr_t        wq[$];
  logic [5:0] gq[$];
  int         n_cmp = 0;
  int         n_bad = 0;

  always @(negedge clk2) if (out_wr === 1'b1) wq.push_back({out_data, out_sop, out_eop});

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int k);
    return (k == 0) ? 8'h47 : 8'(k);
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk2);
      in_valid = '0;
      out_full = 1'b0;
    end
  endtask

  // Drives one packet per stream in mask; returns early when a stream reaches abort_at.
  task automatic run(input logic [3:0] mask, input int stall_at, input bit toggle,
                     input int abort_at);
    int   idx[4];
    int   cyc        = 0;
    int   stall_left = 0;
    bit   stall_done = 1'b0;
    bit   prev_acc   = 1'b0;
    bit   done       = 1'b0;
    logic [3:0] last_v = '0;
    for (int s = 0; s < 4; s++) idx[s] = mask[s] ? 0 : N;
    while (!done && cyc < 3000) begin
      @(negedge clk2);
      chk("wr_latency", {31'd0, out_wr}, {31'd0, prev_acc});
      if (valid !== last_v && valid !== 4'b0) gq.push_back({valid, mux_ctrl});
      last_v = valid;
      for (int s = 0; s < 4; s++) begin
        if (mask[s] && idx[s] == abort_at) return;
        if (mask[s] && idx[s] == stall_at && !stall_done) begin
          stall_left = 5;
          stall_done = 1'b1;
        end
      end
      out_full = (stall_left > 0);
      if (stall_left > 0) begin
        chk("cnt_frozen", 32'(dut.cnt_q), stall_at);
        stall_left--;
      end
      for (int s = 0; s < 4; s++) begin
        in_valid[s]       = (idx[s] < N) && (!toggle || (cyc % 2 == 0));
        in_data[8*s +: 8] = exp_byte((idx[s] < N) ? idx[s] : 0);
      end
      #1;
      chk("sync_err_quiet", 32'(sync_err), 0);
      prev_acc = 1'b0;
      for (int s = 0; s < 4; s++) begin
        if (in_valid[s] && in_ready[s]) begin
          idx[s]++;
          prev_acc = 1'b1;
        end
      end
      done = 1'b1;
      for (int s = 0; s < 4; s++) if (idx[s] < N) done = 1'b0;
      cyc++;
    end
    chk("run_timeout", {31'd0, done}, 1);
  endtask

  task automatic check_pkts(input int npk);
    int bad = 0;
    chk("pkt_count", wq.size(), npk * N);
    for (int i = 0; i < wq.size(); i++) begin
      int k = i % N;
      if (wq[i].d !== exp_byte(k) || wq[i].sop !== (k == 0) || wq[i].eop !== (k == N - 1))
        bad++;
    end
    chk("pkt_content", bad, 0);
    wq.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(valid), 0);
    chk({tag, "_mux_ctrl"}, 32'(mux_ctrl), 0);
    chk({tag, "_out_wr"}, 32'(out_wr), 0);
    chk({tag, "_out_data"}, 32'(out_data), 0);
    chk({tag, "_sop_eop"}, 32'({out_sop, out_eop}), 0);
    chk({tag, "_in_ready"}, 32'(in_ready), 0);
    chk({tag, "_sync_err"}, 32'(sync_err), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int eops;
    rst_n    = 1'b0;
    in_data  = '0;
    in_valid = '0;
    out_full = 1'b0;

    // Reset state, with a non-sync byte offered that must not be accepted.
    #2;
    in_valid = 4'b0001;
    in_data  = 32'h0000_0012;
    #1;
    chk_all_zero("reset");
    in_valid = '0;
    repeat (2) @(negedge clk2);
    rst_n = 1'b1;
    idle(2);

    // Single packet on stream 1.
    run(4'b0010, -1, 1'b0, -1);
    idle(4);
    chk("t1_grant_cnt", gq.size(), 1);
    chk("t1_grant", (gq.size() > 0) ? 32'(gq[0]) : 32'hffff, 32'b0010_01);
    chk("t1_valid_after", 32'(valid), 0);
    chk("t1_mux_hold", 32'(mux_ctrl), 1);
    check_pkts(1);
    gq.delete();

    // All four streams ready together with rr_ptr back at 0.
    @(negedge clk2);
    #2 rst_n = 1'b0;
    @(negedge clk2);
    rst_n = 1'b1;
    idle(1);
    run(4'b1111, -1, 1'b0, -1);
    idle(4);
    chk("t2_grant_cnt", gq.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("t2_grant_order", (gq.size() > i) ? 32'(gq[i]) : 32'hffff, 32'({4'(1 << i), 2'(i)}));
    check_pkts(4);
    gq.delete();

    // Stream 2 leads with two non-sync bytes.
    @(negedge clk2);
    in_valid = 4'b0100;
    in_data  = 32'h0000_0000;
    #1;
    chk("t3_sync_err_0", 32'(sync_err), 32'b0100);
    chk("t3_ready_0", 32'(in_ready), 32'b0100);
    @(negedge clk2);
    in_data[23:16] = 8'h12;
    #1;
    chk("t3_sync_err_1", 32'(sync_err), 32'b0100);
    chk("t3_ready_1", 32'(in_ready), 32'b0100);
    run(4'b0100, -1, 1'b0, -1);
    idle(4);
    chk("t3_grant", (gq.size() > 0) ? 32'(gq[0]) : 32'hffff, 32'b0100_10);
    check_pkts(1);
    gq.delete();

    // Downstream full for 5 cycles at count 50.
    run(4'b0001, 50, 1'b0, -1);
    idle(4);
    check_pkts(1);
    gq.delete();

    // Source valid toggling every other cycle.
    run(4'b0010, -1, 1'b1, -1);
    idle(4);
    check_pkts(1);
    gq.delete();

    // Reset mid-packet at count 100 on stream 3, then a clean packet.
    run(4'b1000, -1, 1'b0, 100);
    chk("t6_pre_mux", 32'(mux_ctrl), 3);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("t6_abort");
    in_valid = '0;
    idle(2);
    @(negedge clk2);
    rst_n = 1'b1;
    chk("t6_partial_writes", wq.size(), 100);
    eops = 0;
    foreach (wq[i]) if (wq[i].eop) eops++;
    chk("t6_no_eop", eops, 0);
    wq.delete();
    gq.delete();
    idle(1);
    run(4'b1000, -1, 1'b0, -1);
    idle(4);
    chk("t6_grant", (gq.size() > 0) ? 32'(gq[0]) : 32'hffff, 32'b1000_11);
    check_pkts(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ts_packet_mux.md
TS_PACKET_MUX -- requirements
Module: ts_packet_mux

Interface
REQ-001 Parameter PKT_LEN, default 188: TS packet length in bytes.
REQ-002 Parameter SYNC_BYTE, default 8'h47: TS sync byte value.
REQ-003 clk2  input  1  single system clock (100 MHz); all logic on posedge clk2.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_data  input  32  four byte lanes; stream i on bits [8i+7:8i].
REQ-006 in_valid  input  4  per-stream byte-valid.
REQ-007 in_ready  output  4  per-stream byte-accept; a byte is consumed when in_valid[i] && in_ready[i].
REQ-008 out_full  input  1  downstream FIFO full, asserted with at least 1 entry of margin.
REQ-009 out_data  output  8  muxed byte, registered.
REQ-010 out_wr  output  1  one-cycle write strobe for out_data.
REQ-011 out_sop / out_eop  output  1 each  qualify out_wr for byte 0 / byte PKT_LEN-1.
REQ-012 valid  output  4  one-hot of the currently granted stream; all zero when none is granted.
REQ-013 mux_ctrl  output  2  index of the granted stream; holds the last grant when idle.
REQ-014 sync_err  output  4  one-cycle pulse per stream on each discarded non-sync byte.

Function
REQ-015 The FSM SHALL have states IDLE, XFER and FLUSH.
- IDLE: choose a grant.
- XFER: forward one packet.
- FLUSH: the cycle after the last byte; update the round-robin pointer.
REQ-016 In IDLE, a stream SHALL be eligible when in_valid[i]=1 and its lane equals SYNC_BYTE.
REQ-017 In IDLE, the eligible stream nearest after rr_ptr (wrapping 3->0) SHALL be granted, and the FSM SHALL go to XFER on the next cycle.
REQ-018 In IDLE, any stream with in_valid=1 and a non-sync lane SHALL have in_ready=1 (byte discarded) and SHALL pulse sync_err[i] for that cycle.
REQ-019 In XFER, in_ready[g] SHALL equal !out_full; all other in_ready SHALL be 0.
REQ-020 Each accepted byte SHALL appear on out_data with out_wr=1 exactly 1 cycle later (latency 1).
REQ-021 The byte counter is ceil(log2(PKT_LEN)) bits, starts at 0 on grant, increments per accepted byte, and SHALL NOT advance on stalls (in_valid[g]=0 or out_full=1).
REQ-022 out_sop SHALL assert with the byte at count 0; out_eop SHALL assert with the byte at count PKT_LEN-1.
REQ-023 Accepting the byte at count PKT_LEN-1 SHALL move the FSM to FLUSH.
REQ-024 In FLUSH, rr_ptr SHALL become g+1 mod 4, valid SHALL clear, and the FSM SHALL return to IDLE; in FLUSH no stream is granted.
REQ-025 In-packet bytes SHALL NOT be checked for sync; byte 0 is already qualified by REQ-016.
REQ-026 If out_full rises mid-packet, the FSM SHALL remain in XFER and the counter SHALL hold; no byte is lost or duplicated.
REQ-027 When several streams are eligible in the same cycle, REQ-017 alone SHALL decide the grant; the others are held with in_ready=0.
REQ-028 valid SHALL be nonzero only in XFER, so the downstream clock divider runs only while a packet is forwarded.

Reset
REQ-029 On rst_n=0, immediately and regardless of clk2:
- state=IDLE, rr_ptr=0, counter=0, mux_ctrl=0;
- valid, out_data, out_wr, out_sop, out_eop, sync_err, in_ready all 0.
REQ-030 Reset mid-packet SHALL abandon the packet without emitting an eop.
REQ-031 Reset release SHALL take effect on the first posedge clk2 after rst_n=1.

Structure
REQ-032 A shared package SHALL hold PKT_LEN, SYNC_BYTE, the state encoding and NUM_STREAMS=4.
REQ-033 The round-robin selector SHALL be a sub-module, rr_arbiter4.
- Inputs: 4-bit request and 2-bit pointer.
- Outputs: one-hot grant and index.
REQ-034 There SHALL be no other sub-modules.

Verification
REQ-035 Reset release; stream 1 sends 188 bytes 0x47,0x01..0xBB back-to-back -> valid=4'b0010, mux_ctrl=1, 188 out_wr pulses, sop on 0x47, eop on 0xBB, then valid=0.
REQ-036 All four streams present 0x47 in the same cycle, rr_ptr=0 -> grant order 0,1,2,3 on successive packets; each packet completes before the next grant.
REQ-037 Stream 2 sends 0x00,0x12 then 0x47 -> two sync_err[2] pulses, and packet capture starts on the 0x47 byte.
REQ-038 out_full held high for 5 cycles at count 50 -> exactly 188 writes with contiguous byte values; counter frozen during the stall.
REQ-039 rst_n low at count 100 -> all outputs 0 within the same cycle; after release, a new packet starts cleanly from sop with no eop for the abandoned packet.
REQ-040 in_valid[g] toggling every other cycle during XFER -> out_wr follows accepted bytes at 1-cycle latency; the total is still 188.
